// File: rtl/timer_load_arbiter_if.sv
// Bus between the core array, the load arbiter and the shared TIMER_COUNTER.
// slave = arbiter side, master = cores/timer side.
interface timer_load_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
);
    logic [NUM_REQ-1:0]    REQ;
    logic [8*NUM_REQ-1:0]  REQ_CONFIG;
    logic [8*NUM_REQ-1:0]  REQ_PRESC;
    logic [16*NUM_REQ-1:0] REQ_VALUE;
    logic [NUM_REQ-1:0]    ACK;
    logic                  BUSY;
    logic [IDX_W-1:0]      OWNER;
    logic                  TIMER_EN;
    logic                  TIMER_SET_REG;
    logic                  TIMER_SET_PRESC;
    logic                  TIMER_SET_VALUE;
    logic [7:0]            TIMER_DATA;
    logic                  TIMER_OV;
    logic [NUM_REQ-1:0]    IRQ;

    modport slave (
        input  REQ, REQ_CONFIG, REQ_PRESC, REQ_VALUE, TIMER_OV,
        output ACK, BUSY, OWNER, TIMER_EN, TIMER_SET_REG,
        output TIMER_SET_PRESC, TIMER_SET_VALUE, TIMER_DATA, IRQ
    );

    modport master (
        output REQ, REQ_CONFIG, REQ_PRESC, REQ_VALUE, TIMER_OV,
        input  ACK, BUSY, OWNER, TIMER_EN, TIMER_SET_REG,
        input  TIMER_SET_PRESC, TIMER_SET_VALUE, TIMER_DATA, IRQ
    );
endinterface

// File: rtl/timer_load_arbiter.sv
// Round-robin load arbiter sharing one TIMER_COUNTER among NUM_REQ cores.
// Optional overflow IRQ tracking: define TIMER_LOAD_ARB_IRQ_EN.
module timer_load_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                 CLK,
    input  logic                 CPU_Reset,
    timer_load_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_HALT, S_WR_CFG, S_WR_PRE, S_WR_VL, S_WR_VH, S_DONE
    } state_t;

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t             r_state, w_nxt;
    logic [IDX_W-1:0]   r_ptr, r_win, r_owner, w_pick, w_ptr_nxt;
    logic [7:0]         r_cfg, r_presc, r_data, w_data, w_cfg_sel, w_pre_sel;
    logic [15:0]        r_value, w_val_sel;
    logic [NUM_REQ-1:0] r_ack, w_ack;
    logic               r_busy, r_en, r_sr, r_sp, r_sv, r_running;
    logic               w_busy, w_sr, w_sp, w_sv, w_accept, w_found;

    assign w_accept  = (r_state == S_IDLE) && (|bus.REQ);
    assign w_ptr_nxt = (r_win == IDX_W'(NUM_REQ-1)) ? '0 : r_win + 1'b1;

    // Round-robin pick: first request at/after the pointer, then wrap.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && bus.REQ[j] && (IDX_W'(j) >= r_ptr)) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && bus.REQ[j]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(j);
            end
        end
    end

    // Select the picked core's operands for latching at accept.
    always_comb begin
        w_cfg_sel = '0;
        w_pre_sel = '0;
        w_val_sel = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (IDX_W'(j) == w_pick) begin
                w_cfg_sel = bus.REQ_CONFIG[j*8 +: 8];
                w_pre_sel = bus.REQ_PRESC[j*8 +: 8];
                w_val_sel = bus.REQ_VALUE[j*16 +: 16];
            end
        end
    end

    // Next state plus registered outputs valid for the whole next state.
    always_comb begin
        w_nxt  = r_state;
        w_busy = 1'b0;
        w_sr   = 1'b0;
        w_sp   = 1'b0;
        w_sv   = 1'b0;
        w_data = '0;
        w_ack  = '0;
        unique case (r_state)
            S_IDLE:   if (|bus.REQ) w_nxt = S_HALT;
            S_HALT:   w_nxt = S_WR_CFG;
            S_WR_CFG: w_nxt = S_WR_PRE;
            S_WR_PRE: w_nxt = S_WR_VL;
            S_WR_VL:  w_nxt = S_WR_VH;
            S_WR_VH:  w_nxt = S_DONE;
            default:  w_nxt = S_IDLE;
        endcase
        unique case (w_nxt)
            S_HALT:   w_busy = 1'b1;
            S_WR_CFG: begin w_busy = 1'b1; w_sr = 1'b1; w_data = r_cfg; end
            S_WR_PRE: begin w_busy = 1'b1; w_sp = 1'b1; w_data = r_presc; end
            S_WR_VL:  begin w_busy = 1'b1; w_sv = 1'b1; w_data = r_value[7:0]; end
            S_WR_VH:  begin w_busy = 1'b1; w_sv = 1'b1; w_data = r_value[15:8]; end
            S_DONE:   w_ack = ONE << r_win;
            default:  ;
        endcase
    end

    // State, latched operands, timer control and ownership registers.
    always_ff @(posedge CLK) begin
        if (CPU_Reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_owner   <= '0;
            r_cfg     <= '0;
            r_presc   <= '0;
            r_value   <= '0;
            r_data    <= '0;
            r_ack     <= '0;
            r_busy    <= 1'b0;
            r_en      <= 1'b1;
            r_sr      <= 1'b0;
            r_sp      <= 1'b0;
            r_sv      <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_data  <= w_data;
            r_ack   <= w_ack;
            r_busy  <= w_busy;
            r_sr    <= w_sr;
            r_sp    <= w_sp;
            r_sv    <= w_sv;
            if (w_accept) begin
                r_win   <= w_pick;
                r_cfg   <= w_cfg_sel;
                r_presc <= w_pre_sel;
                r_value <= w_val_sel;
            end
            if (w_nxt == S_HALT) begin
                r_en      <= 1'b1;
                r_running <= 1'b0;
            end
            if (w_nxt == S_DONE) begin
                r_en      <= 1'b0;
                r_running <= 1'b1;
                r_owner   <= r_win;
                r_ptr     <= w_ptr_nxt;
            end
        end
    end

    assign bus.ACK             = r_ack;
    assign bus.BUSY            = r_busy;
    assign bus.OWNER           = r_owner;
    assign bus.TIMER_EN        = r_en;
    assign bus.TIMER_SET_REG   = r_sr;
    assign bus.TIMER_SET_PRESC = r_sp;
    assign bus.TIMER_SET_VALUE = r_sv;
    assign bus.TIMER_DATA      = r_data;

`ifdef TIMER_LOAD_ARB_IRQ_EN
    logic               r_ov_q, w_ov_rise;
    logic [NUM_REQ-1:0] r_irq, w_irq_set, w_irq_clr;

    assign w_ov_rise = r_running && (bus.TIMER_OV == 1'b1) && !r_ov_q;
    assign w_irq_set = w_ov_rise ? (ONE << r_owner) : '0;
    assign w_irq_clr = w_accept ? (ONE << w_pick) : '0;

    // Sticky overflow flags; accepting a core's new load clears its flag.
    always_ff @(posedge CLK) begin
        if (CPU_Reset) begin
            r_ov_q <= 1'b0;
            r_irq  <= '0;
        end else begin
            r_ov_q <= (bus.TIMER_OV == 1'b1);
            r_irq  <= (r_irq | w_irq_set) & ~w_irq_clr;
        end
    end

    assign bus.IRQ = r_irq;
`else
    logic [1:0] w_unused_irq;
    assign w_unused_irq = {bus.TIMER_OV, r_running};
    assign bus.IRQ = '0;
`endif
endmodule

// File: tb/tb_timer_load_arbiter.sv
// Directed bench for timer_load_arbiter, NUM_REQ=4.
// Table-driven first load plus hand sequences for multi-cycle cases.
module tb_timer_load_arbiter;
    logic clk;
    logic rst;

    timer_load_arbiter_if #(.NUM_REQ(4), .IDX_W(2)) bus ();

    timer_load_arbiter #(.NUM_REQ(4), .IDX_W(2)) dut (
        .CLK       (clk),
        .CPU_Reset (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int n_excl = 0;

    typedef struct {
        logic [3:0] req;
        logic       busy;
        logic       en;
        logic       sr;
        logic       sp;
        logic       sv;
        logic [7:0] data;
        logic [3:0] ack;
        logic [1:0] owner;
    } vec_t;

    vec_t tbl [8];

    // Strobes must never overlap.
    always @(negedge clk) begin
        if (!rst && (int'(bus.TIMER_SET_REG) + int'(bus.TIMER_SET_PRESC)
                     + int'(bus.TIMER_SET_VALUE) > 1))
            n_excl++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int k, input logic [7:0] c,
                            input logic [7:0] p, input logic [15:0] v);
        bus.REQ_CONFIG[k*8 +: 8]  = c;
        bus.REQ_PRESC[k*8 +: 8]   = p;
        bus.REQ_VALUE[k*16 +: 16] = v;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.REQ = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output int cyc,
                            output logic [3:0] av);
        cyc = 0;
        av  = '0;
        while (cyc < budget) begin
            tick();
            cyc++;
            if (bus.ACK != 0) begin
                av = bus.ACK;
                break;
            end
        end
    endtask

    task automatic chk_strobes_idle(input string name);
        chk({name, "_sr"}, 32'(bus.TIMER_SET_REG), 0);
        chk({name, "_sp"}, 32'(bus.TIMER_SET_PRESC), 0);
        chk({name, "_sv"}, 32'(bus.TIMER_SET_VALUE), 0);
    endtask

    initial begin
        int         cyc;
        logic [3:0] av;
        int         at [5];
        logic [3:0] aq [5];
        logic [3:0] exp_rr [5];
        int         nack;
        int         t;

        rst          = 1'b1;
        bus.REQ      = '0;
        bus.TIMER_OV = 1'b0;
        set_core(0, 8'h40, 8'h03, 16'h12AB);
        set_core(1, 8'h11, 8'h21, 16'h3141);
        set_core(2, 8'hC1, 8'h05, 16'h3456);
        set_core(3, 8'h13, 8'h23, 16'h3343);

        tbl[0] = '{4'b0001, 1, 1, 0, 0, 0, 8'h00, 4'b0000, 2'd0};
        tbl[1] = '{4'b0001, 1, 1, 1, 0, 0, 8'h40, 4'b0000, 2'd0};
        tbl[2] = '{4'b0001, 1, 1, 0, 1, 0, 8'h03, 4'b0000, 2'd0};
        tbl[3] = '{4'b0001, 1, 1, 0, 0, 1, 8'hAB, 4'b0000, 2'd0};
        tbl[4] = '{4'b0001, 1, 1, 0, 0, 1, 8'h12, 4'b0000, 2'd0};
        tbl[5] = '{4'b0001, 0, 0, 0, 0, 0, 8'h00, 4'b0001, 2'd0};
        tbl[6] = '{4'b0000, 0, 0, 0, 0, 0, 8'h00, 4'b0000, 2'd0};
        tbl[7] = '{4'b0000, 0, 0, 0, 0, 0, 8'h00, 4'b0000, 2'd0};

        // Reset values
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_en", 32'(bus.TIMER_EN), 1);
        chk_strobes_idle("rst");
        chk("rst_data", 32'(bus.TIMER_DATA), 0);
        chk("rst_ack", 32'(bus.ACK), 0);
        chk("rst_busy", 32'(bus.BUSY), 0);
        chk("rst_owner", 32'(bus.OWNER), 0);
        chk("rst_irq", 32'(bus.IRQ), 0);

        // First load, one row per cycle
        for (int i = 0; i < 8; i++) begin
            bus.REQ = tbl[i].req;
            tick();
            chk($sformatf("t1_busy%0d", i), 32'(bus.BUSY), 32'(tbl[i].busy));
            chk($sformatf("t1_en%0d", i), 32'(bus.TIMER_EN), 32'(tbl[i].en));
            chk($sformatf("t1_sr%0d", i), 32'(bus.TIMER_SET_REG), 32'(tbl[i].sr));
            chk($sformatf("t1_sp%0d", i), 32'(bus.TIMER_SET_PRESC), 32'(tbl[i].sp));
            chk($sformatf("t1_sv%0d", i), 32'(bus.TIMER_SET_VALUE), 32'(tbl[i].sv));
            if (tbl[i].sr || tbl[i].sp || tbl[i].sv)
                chk($sformatf("t1_data%0d", i), 32'(bus.TIMER_DATA), 32'(tbl[i].data));
            chk($sformatf("t1_ack%0d", i), 32'(bus.ACK), 32'(tbl[i].ack));
            chk($sformatf("t1_owner%0d", i), 32'(bus.OWNER), 32'(tbl[i].owner));
        end

        // All four held: round-robin order and spacing
        do_reset();
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            at[i] = 0;
            aq[i] = '0;
        end
        nack    = 0;
        t       = 0;
        bus.REQ = 4'b1111;
        while (nack < 5 && t < 60) begin
            tick();
            t++;
            if (bus.ACK != 0) begin
                at[nack] = t;
                aq[nack] = bus.ACK;
                nack++;
            end
        end
        bus.REQ = '0;
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_ack%0d", i), 32'(aq[i]), 32'(exp_rr[i]));
        chk("rr_lat0", 32'(at[0]), 6);
        for (int i = 1; i < 5; i++)
            chk($sformatf("rr_gap%0d", i), 32'(at[i] - at[i-1]), 7);
        tick();

        // Operands frozen after accept
        do_reset();
        set_core(2, 8'hC1, 8'h05, 16'h3456);
        bus.REQ = 4'b0100;
        tick();
        chk("fz_halt_busy", 32'(bus.BUSY), 1);
        bus.REQ = 4'b0001;
        set_core(2, 8'h00, 8'h00, 16'hFFFF);
        tick();
        chk("fz_cfg", {bus.TIMER_SET_REG, bus.TIMER_DATA}, {1'b1, 8'hC1});
        tick();
        chk("fz_pre", {bus.TIMER_SET_PRESC, bus.TIMER_DATA}, {1'b1, 8'h05});
        tick();
        chk("fz_vl", {bus.TIMER_SET_VALUE, bus.TIMER_DATA}, {1'b1, 8'h56});
        tick();
        chk("fz_vh", {bus.TIMER_SET_VALUE, bus.TIMER_DATA}, {1'b1, 8'h34});
        tick();
        chk("fz_ack", 32'(bus.ACK), 32'(4'b0100));
        chk("fz_owner", 32'(bus.OWNER), 2);
        bus.REQ = '0;
        set_core(2, 8'hC1, 8'h05, 16'h3456);
        tick();
        chk("fz_idle_ack", 32'(bus.ACK), 0);

        // Reset during WR_PRE
        do_reset();
        bus.REQ = 4'b0001;
        wait_ack(20, cyc, av);
        chk("ra_first_ack", 32'(av), 32'(4'b0001));
        bus.REQ = '0;
        tick();
        bus.REQ = 4'b0001;
        tick();
        tick();
        tick();
        chk("ra_in_pre", 32'(bus.TIMER_SET_PRESC), 1);
        rst     = 1'b1;
        bus.REQ = '0;
        tick();
        chk_strobes_idle("ra");
        chk("ra_en", 32'(bus.TIMER_EN), 1);
        chk("ra_ack", 32'(bus.ACK), 0);
        chk("ra_busy", 32'(bus.BUSY), 0);
        rst     = 1'b0;
        bus.REQ = 4'b1001;
        wait_ack(20, cyc, av);
        chk("ra_grant", 32'(av), 32'(4'b0001));
        chk("ra_lat", 32'(cyc), 6);
        bus.REQ = '0;
        tick();

        // Preempt a running core
        do_reset();
        bus.REQ = 4'b0010;
        wait_ack(20, cyc, av);
        chk("pe_ack1", 32'(av), 32'(4'b0010));
        bus.REQ = '0;
        tick();
        chk("pe_run_en", 32'(bus.TIMER_EN), 0);
        chk("pe_run_owner", 32'(bus.OWNER), 1);
        bus.REQ = 4'b0001;
        tick();
        chk("pe_halt_en", 32'(bus.TIMER_EN), 1);
        chk("pe_halt_owner", 32'(bus.OWNER), 1);
        wait_ack(20, cyc, av);
        chk("pe_ack0", 32'(av), 32'(4'b0001));
        chk("pe_owner", 32'(bus.OWNER), 0);
        chk("pe_en", 32'(bus.TIMER_EN), 0);
        bus.REQ = '0;
        tick();

        // Overflow IRQ
        do_reset();
        bus.REQ = 4'b0100;
        wait_ack(20, cyc, av);
        chk("irq_ack", 32'(av), 32'(4'b0100));
        bus.REQ = '0;
        tick();
        bus.TIMER_OV = 1'b1;
        tick();
`ifdef TIMER_LOAD_ARB_IRQ_EN
        chk("irq_set", 32'(bus.IRQ), 32'(4'b0100));
        tick();
        tick();
        chk("irq_hold", 32'(bus.IRQ), 32'(4'b0100));
        bus.REQ = 4'b0100;
        tick();
        chk("irq_clr", 32'(bus.IRQ), 0);
`else
        chk("irq_off", 32'(bus.IRQ), 0);
        tick();
        chk("irq_off_hold", 32'(bus.IRQ), 0);
`endif
        bus.TIMER_OV = 1'b0;
        bus.REQ      = '0;
        repeat (8) tick();

        chk("strobe_excl", 32'(n_excl), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
